// File: rtl/and_array_sched.sv
// Round-robin scheduler sharing one WIDTH-lane AND array among NREQ requesters.
// Define AND_ARRAY_SCHED_RR_EN for rotating priority; otherwise fixed priority (lowest index wins).

module and_cell (
   input  logic i_a,
   input  logic i_b,
   output logic o_y
);
   assign o_y = i_a & i_b;
endmodule

module and_array_sched #(
   parameter  int NREQ  = 4,
   parameter  int WIDTH = 4,
   localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [WIDTH-1:0]      res_data,
   output logic [IDW-1:0]        res_id
);

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_data;
   logic [IDW-1:0]     r_id;
   logic [IDW-1:0]     w_ptr;
   logic               w_slot_free;
   logic               w_gnt_valid;
   logic [IDW-1:0]     w_gnt_idx;
   logic [IDW:0]       w_cand;
   logic [WIDTH-1:0]   w_sel_a;
   logic [WIDTH-1:0]   w_sel_b;
   logic [WIDTH-1:0]   w_and;

`ifdef AND_ARRAY_SCHED_RR_EN
   logic [IDW-1:0]     r_ptr;

   // Rotating pointer: advances past the winner on every grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (w_gnt_valid) begin
         if (w_gnt_idx == IDW'(NREQ - 1)) begin
            r_ptr <= '0;
         end else begin
            r_ptr <= w_gnt_idx + IDW'(1);
         end
      end else begin
         r_ptr <= r_ptr;
      end
   end

   assign w_ptr = r_ptr;
`else
   assign w_ptr = '0;
`endif

   assign w_slot_free = (r_state == ST_EMPTY) || res_ready;

   // Arbitration: first valid requester starting at ptr, wrapping modulo NREQ.
   always_comb begin
      w_gnt_valid = 1'b0;
      w_gnt_idx   = '0;
      w_cand      = '0;
      if (w_slot_free && !rst) begin
         for (int k = 0; k < NREQ; k++) begin
            w_cand = {1'b0, w_ptr} + (IDW+1)'(k);
            if (w_cand >= (IDW+1)'(NREQ)) begin
               w_cand = w_cand - (IDW+1)'(NREQ);
            end else begin
               w_cand = w_cand;
            end
            if (!w_gnt_valid && req_valid[w_cand[IDW-1:0]]) begin
               w_gnt_valid = 1'b1;
               w_gnt_idx   = w_cand[IDW-1:0];
            end else begin
               w_gnt_valid = w_gnt_valid;
            end
         end
      end else begin
         w_gnt_valid = 1'b0;
      end
   end

   // One-hot grant decode; never depends on operand values.
   always_comb begin
      req_ready = '0;
      if (w_gnt_valid) begin
         req_ready[w_gnt_idx] = 1'b1;
      end else begin
         req_ready = '0;
      end
   end

   assign w_sel_a = req_a[w_gnt_idx*WIDTH +: WIDTH];
   assign w_sel_b = req_b[w_gnt_idx*WIDTH +: WIDTH];

   for (genvar l = 0; l < WIDTH; l++) begin : g_lane
      and_cell u_cell (
         .i_a (w_sel_a[l]),
         .i_b (w_sel_b[l]),
         .o_y (w_and[l])
      );
   end

   // Output slot state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Slot next-state: a grant always (re)fills; drain without grant empties.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_EMPTY: begin
            if (w_gnt_valid) begin
               w_state_nxt = ST_FULL;
            end else begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (w_gnt_valid) begin
               w_state_nxt = ST_FULL;
            end else if (res_ready) begin
               w_state_nxt = ST_EMPTY;
            end else begin
               w_state_nxt = ST_FULL;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   // Result registers hold their value until the next grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data <= '0;
         r_id   <= '0;
      end else if (w_gnt_valid) begin
         r_data <= w_and;
         r_id   <= w_gnt_idx;
      end else begin
         r_data <= r_data;
         r_id   <= r_id;
      end
   end

   assign res_valid = (r_state == ST_FULL);
   assign res_data  = r_data;
   assign res_id    = r_id;

endmodule

// File: tb/tb_and_array_sched.sv
// Self-checking bench for and_array_sched (NREQ=4, WIDTH=4): constant vector table,
// hand-written corner sequences, and a random phase checked against a reference model + scoreboard.

module tb_and_array_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic        res_valid;
   logic        res_ready;
   logic [3:0]  res_data;
   logic [1:0]  res_id;

   and_array_sched #(.NREQ(4), .WIDTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_id    (res_id)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic       m_full;
   logic [1:0] m_id;
   logic [3:0] m_data;
   int         m_ptr;
   int         m_gnt;
   logic [5:0] sb[$];

   typedef struct {
      logic [3:0]  valid;
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  exp_ready;
      logic        exp_valid;
      logic [1:0]  exp_id;
      logic [3:0]  exp_data;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int exp_grant();
      int idx;
      if (rst || !(!m_full || res_ready)) return -1;
      for (int k = 0; k < 4; k++) begin
         idx = (m_ptr + k) % 4;
         if (req_valid[idx]) return idx;
      end
      return -1;
   endfunction

   // One clock cycle with model comparison on both sides of the edge.
   task automatic tick();
      int         g;
      logic [3:0] erdy;
      logic [5:0] e;
      @(negedge clk);
      g    = exp_grant();
      erdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      chk("req_ready", {28'd0, req_ready}, {28'd0, erdy});
      if (g >= 0) sb.push_back({g[1:0], req_a[g*4 +: 4] & req_b[g*4 +: 4]});
      @(posedge clk);
      if (rst) begin
         m_full = 1'b0; m_ptr = 0; m_id = 2'd0; m_data = 4'd0;
         sb.delete();
      end else if (g >= 0) begin
         m_full = 1'b1;
`ifdef AND_ARRAY_SCHED_RR_EN
         m_ptr = (g + 1) % 4;
`endif
      end else if (m_full && res_ready) begin
         m_full = 1'b0;
      end
      m_gnt = g;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         m_id = e[5:4];
         m_data = e[3:0];
      end
      chk("res_valid", {31'd0, res_valid}, {31'd0, m_full});
      chk("res_id", {30'd0, res_id}, {30'd0, m_id});
      chk("res_data", {28'd0, res_data}, {28'd0, m_data});
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      for (int i = 0; i < n; i++) tick();
      rst = 1'b0;
   endtask

   int rot_exp[6];
   int wrap_exp[3];

   initial begin
      vecs[0] = '{4'b0100, 16'h5BA3, 16'h96C9, 4'b0100, 1'b1, 2'd2, 4'b0010};
      vecs[1] = '{4'b0000, 16'hFFFF, 16'hFFFF, 4'b0000, 1'b0, 2'd0, 4'b0000};
      vecs[2] = '{4'b1010, 16'h37F2, 16'hE85D, 4'b0010, 1'b1, 2'd1, 4'b0101};
      vecs[3] = '{4'b1000, 16'hC1E4, 16'hA7B2, 4'b1000, 1'b1, 2'd3, 4'b1000};
      vecs[4] = '{4'b1111, 16'h9AD7, 16'h458E, 4'b0001, 1'b1, 2'd0, 4'b0110};
`ifdef AND_ARRAY_SCHED_RR_EN
      rot_exp  = '{0, 1, 2, 3, 0, 1};
      wrap_exp = '{3, 0, 3};
`else
      rot_exp  = '{0, 0, 0, 0, 0, 0};
      wrap_exp = '{0, 0, 0};
`endif
      m_full = 1'b0; m_ptr = 0; m_id = 2'd0; m_data = 4'd0; m_gnt = -1;
      rst = 1'b1; req_valid = 4'b1111; req_a = 16'hFFFF; req_b = 16'hFFFF; res_ready = 1'b1;
      @(posedge clk); #1;

      // Reset held 3 cycles with every requester valid
      for (int i = 0; i < 3; i++) begin
         chk("rst_ready", {28'd0, req_ready}, 32'd0);
         tick();
         chk("rst_valid", {31'd0, res_valid}, 32'd0);
         chk("rst_data", {28'd0, res_data}, 32'd0);
         chk("rst_id", {30'd0, res_id}, 32'd0);
      end
      rst = 1'b0;

      // Constant vector table, each from a fresh reset
      for (int v = 0; v < 5; v++) begin
         req_valid = 4'b0000;
         do_reset(1);
         req_valid = vecs[v].valid; req_a = vecs[v].a; req_b = vecs[v].b; res_ready = 1'b1;
         #1;
         chk("vec_ready", {28'd0, req_ready}, {28'd0, vecs[v].exp_ready});
         tick();
         chk("vec_valid", {31'd0, res_valid}, {31'd0, vecs[v].exp_valid});
         chk("vec_id", {30'd0, res_id}, {30'd0, vecs[v].exp_id});
         chk("vec_data", {28'd0, res_data}, {28'd0, vecs[v].exp_data});
      end

      // Rotation / fixed priority with all four continuously valid
      req_valid = 4'b0000; do_reset(1);
      req_valid = 4'b1111; req_a = 16'hA5C3; req_b = 16'hFFFF; res_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("rot_valid", {31'd0, res_valid}, 32'd1);
         chk("rot_id", {30'd0, res_id}, rot_exp[i]);
      end

      // Backpressure: slot full with id 1, consumer stalls 4 cycles
      req_valid = 4'b0000; do_reset(1);
      req_valid = 4'b0010; req_a = 16'h3C96; req_b = 16'hF0F0; res_ready = 1'b1;
      tick();
      req_valid = 4'b1111; res_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("bp_ready", {28'd0, req_ready}, 32'd0);
         tick();
         chk("bp_id", {30'd0, res_id}, 32'd1);
         chk("bp_data", {28'd0, res_data}, 32'h9);
      end
      res_ready = 1'b1;
      #1;
`ifdef AND_ARRAY_SCHED_RR_EN
      chk("bp_release", {28'd0, req_ready}, 32'b0100);
`else
      chk("bp_release", {28'd0, req_ready}, 32'b0001);
`endif
      tick();
      chk("bp_full", {31'd0, res_valid}, 32'd1);

      // Wrap-around: grant 2 moves ptr to 3, then 1001 pattern
      req_valid = 4'b0000; do_reset(1);
      req_valid = 4'b0100; res_ready = 1'b1;
      tick();
      req_valid = 4'b1001;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("wrap_id", {30'd0, res_id}, wrap_exp[i]);
      end

      // Reset mid-stream while full with pending requests
      req_valid = 4'b1111; res_ready = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      chk("mid_rst_ready", {28'd0, req_ready}, 32'd0);
      tick();
      chk("mid_rst_valid", {31'd0, res_valid}, 32'd0);
      rst = 1'b0; req_valid = 4'b0110; res_ready = 1'b1;
      #1;
      chk("mid_rst_grant", {28'd0, req_ready}, 32'b0010);
      tick();
      chk("mid_rst_id", {30'd0, res_id}, 32'd1);

      // Random traffic, requesters hold until granted
      req_valid = 4'b0000;
      for (int c = 0; c < 400; c++) begin
         res_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < 4; i++) begin
            if (!req_valid[i] || m_gnt == i) begin
               req_valid[i] = $urandom_range(0, 1);
               req_a[i*4 +: 4] = 4'($urandom_range(0, 15));
               req_b[i*4 +: 4] = 4'($urandom_range(0, 15));
            end
         end
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/and_array_sched.md
# and_array_sched

Round-robin scheduler that shares one WIDTH-bit bitwise-AND lane array among NREQ requesters. Each requester offers an operand pair over a valid/ready handshake. The scheduler grants one requester per cycle, drives the shared array, and registers the result together with the requester index into a single output slot. It sits between several producer blocks and the lane array, which is instantiated as an array of single-bit AND cells.

## Interface
- NREQ, 4, number of requesters (2..16)
- WIDTH, 4, lane count; operand and result width
- IDW, max(1, $clog2(NREQ)), requester index width (derived, not overridden)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  requester i offers an operand pair
- req_ready  out  NREQ  one-hot (or zero) grant; transfer when req_valid[i] & req_ready[i]
- req_a  in  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand B, same packing
- res_valid  out  1  output slot holds a result
- res_ready  in  1  consumer accepts; transfer when res_valid & res_ready
- res_data  out  WIDTH  a & b of the granted pair
- res_id  out  IDW  index of the requester that produced res_data

## Operation
- Output slot FSM has two states:
  - EMPTY (res_valid=0).
  - FULL (res_valid=1).
- The slot can accept a new pair (slot_free) when state is EMPTY, or when state is FULL and res_ready=1.
- Arbitration is combinational:
  - Only when slot_free=1 and rst=0 does the scheduler pick the first i with req_valid[i]=1, searching i = ptr, ptr+1, … mod NREQ.
  - req_ready has that single bit set; all other bits are 0.
  - If no request is valid, or slot_free=0, req_ready is all zero.
- On a grant to g at a clock edge:
  - res_data <= req_a[g] & req_b[g], computed through the lane array.
  - res_id <= g.
  - State goes to FULL.
  - ptr <= (g+1) mod NREQ, wrapping from NREQ-1 to 0.
- FULL with res_ready=1 and no grant: state goes to EMPTY. res_data and res_id keep their last values.
- FULL with res_ready=0: res_data, res_id and res_valid stay stable; nothing is granted.
- Simultaneous drain and grant in the same cycle: the slot is reloaded and stays FULL, so sustained throughput is one result per cycle.
- ptr changes only on a grant.
- req_ready never depends on req_a or req_b. It may depend on req_valid, res_ready, state and ptr.

## Timing
- Reset values: res_valid=0, res_data=0, res_id=0, ptr=0, state EMPTY, req_ready all zero while rst=1.
- Latency: pair accepted at edge N appears on res_data/res_valid after edge N (visible in cycle N+1).
- Reset mid-operation: a pending result is discarded. No grant is issued in the reset cycle. ptr returns to 0.
- Fairness: with all NREQ requesters continuously valid and res_ready=1, grants rotate 0,1,…,NREQ-1,0. No requester waits more than NREQ-1 grants.
- A requester must hold req_valid, req_a and req_b stable until granted. The scheduler does not check this.

## Configuration
- AND_ARRAY_SCHED_RR_EN
  - Defined: round-robin arbitration with the rotating ptr, as described above.
  - Undefined: fixed priority. ptr is removed (treated as constant 0) and the lowest-index valid requester always wins; a continuously valid requester 0 starves the others.
- Handshake, latency, reset values and result formation are identical in both builds.

## Test plan
- Reset: hold rst=1 for 3 cycles with all req_valid=1 -> req_ready=0, res_valid=0, res_data=0, res_id=0 throughout.
- Single request: NREQ=4, WIDTH=4, req_valid=4'b0100, req_a[2]=4'b1011, req_b[2]=4'b0110, res_ready=1 -> req_ready=4'b0100 in that cycle; next cycle res_valid=1, res_data=4'b0010, res_id=2.
- Rotation (RR_EN defined): all four valid, res_ready=1 for 6 cycles -> res_id sequence 0,1,2,3,0,1, one result per cycle. With the macro undefined -> 0,0,0,0,0,0.
- Backpressure: slot FULL with res_id=1, res_ready=0 for 4 cycles while requesters are valid -> req_ready=0 and res_data/res_id unchanged. Raising res_ready -> same-cycle grant to ptr=2, and the slot stays FULL.
- Wrap-around: ptr=3 with req_valid=4'b1001 -> grant 3, then next grant 0, then ptr=1.
- Reset mid-stream: assert rst for 1 cycle while FULL and requests are pending -> res_valid=0 the next cycle, ptr=0, and the first post-reset grant goes to the lowest valid index.
